// File: rtl/multicycle_control_fsm.sv
// Main sequencer for the multi-cycle RISC-V core: steps the shared ALU, memory port,
// IR and PC through fetch/decode/execute/memory/writeback with a memory-ready handshake.
module multicycle_control_fsm #(
  parameter bit HALT_ON_ILLEGAL = 1'b1,
  parameter int STATE_W         = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [6:0]         op,
  input  logic               zero,
  input  logic               mem_ready,
  output logic [1:0]         ALUOp,
  output logic [1:0]         ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         ResultSrc,
  output logic [1:0]         ImmSrc,
  output logic               AdrSrc,
  output logic               IRWrite,
  output logic               PCWrite,
  output logic               RegWrite,
  output logic               MemWrite,
  output logic               illegal_instr,
  output logic               instr_done,
  output logic [STATE_W-1:0] state_dbg
);

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  typedef enum logic [STATE_W-1:0] {
    FETCH    = STATE_W'(0),
    DECODE   = STATE_W'(1),
    MEMADR   = STATE_W'(2),
    MEMREAD  = STATE_W'(3),
    MEMWB    = STATE_W'(4),
    MEMWRITE = STATE_W'(5),
    EXECUTER = STATE_W'(6),
    ALUWB    = STATE_W'(7),
    EXECUTEI = STATE_W'(8),
    JAL      = STATE_W'(9),
    BEQ      = STATE_W'(10),
    TRAP     = STATE_W'(11)
  } state_t;

  state_t state, state_next;
  logic   pc_update, branch, ir_write, reg_write, mem_write, done;

  always_ff @(posedge clk) begin
    // NOTE: state flops use non-blocking assignment so they all sample pre-edge values.
    if (reset) state <= FETCH;
    else       state <= state_next;
  end

  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    state_next    = FETCH;
    ALUOp         = 2'b00;
    ALUSrcA       = 2'b00;
    ALUSrcB       = 2'b00;
    ResultSrc     = 2'b00;
    AdrSrc        = 1'b0;
    pc_update     = 1'b0;
    branch        = 1'b0;
    ir_write      = 1'b0;
    reg_write     = 1'b0;
    mem_write     = 1'b0;
    done          = 1'b0;
    illegal_instr = 1'b0;
    case (state)
      FETCH: begin
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        // Hold every enable until the fetch completes so the PC advances exactly once.
        if (mem_ready) begin
          ir_write   = 1'b1;
          pc_update  = 1'b1;
          state_next = DECODE;
        end else begin
          state_next = FETCH;
        end
      end
      DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        case (op)
          OP_LW, OP_SW: state_next = MEMADR;
          OP_R:         state_next = EXECUTER;
          OP_I:         state_next = EXECUTEI;
          OP_JAL:       state_next = JAL;
          OP_BEQ:       state_next = BEQ;
          default:      state_next = HALT_ON_ILLEGAL ? TRAP : FETCH;
        endcase
      end
      MEMADR: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        state_next = (op == OP_LW) ? MEMREAD : MEMWRITE;
      end
      MEMREAD: begin
        AdrSrc     = 1'b1;
        state_next = mem_ready ? MEMWB : MEMREAD;
      end
      MEMWB: begin
        ResultSrc = 2'b01;
        reg_write = 1'b1;
        done      = 1'b1;
      end
      MEMWRITE: begin
        AdrSrc    = 1'b1;
        mem_write = 1'b1;
        if (mem_ready) done = 1'b1;
        else           state_next = MEMWRITE;
      end
      EXECUTER: begin
        ALUSrcA    = 2'b10;
        ALUOp      = 2'b10;
        state_next = ALUWB;
      end
      EXECUTEI: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        ALUOp      = 2'b10;
        state_next = ALUWB;
      end
      ALUWB: begin
        reg_write = 1'b1;
        done      = 1'b1;
      end
      JAL: begin
        // PC takes the target from ALUOut while the ALU forms OldPC+4 for the link.
        ALUSrcA    = 2'b01;
        ALUSrcB    = 2'b10;
        pc_update  = 1'b1;
        state_next = ALUWB;
      end
      BEQ: begin
        ALUSrcA = 2'b10;
        ALUOp   = 2'b01;
        branch  = 1'b1;
        done    = 1'b1;
      end
      TRAP: begin
        illegal_instr = 1'b1;
        state_next    = TRAP;
      end
      default: state_next = FETCH;
    endcase
  end

  always_comb begin
    case (op)
      OP_SW:   ImmSrc = 2'b01;
      OP_BEQ:  ImmSrc = 2'b10;
      OP_JAL:  ImmSrc = 2'b11;
      default: ImmSrc = 2'b00;
    endcase
  end

  // Reset suppresses every side effect on the datapath in the cycle it is applied.
  assign IRWrite    = ir_write & ~reset;
  assign PCWrite    = (pc_update | (branch & zero)) & ~reset;
  assign RegWrite   = reg_write & ~reset;
  assign MemWrite   = mem_write & ~reset;
  assign instr_done = done & ~reset;
  assign state_dbg  = state;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Bench for multicycle_control_fsm: two instances (trap / skip on illegal opcodes) are
// driven with directed and random instruction streams against a phase-list reference model.
module tb_multicycle_control_fsm;

  localparam int P_F = 0, P_D = 1, P_MA = 2, P_MR = 3, P_MWB = 4, P_MW = 5;
  localparam int P_ER = 6, P_AWB = 7, P_EI = 8, P_JAL = 9, P_BEQ = 10, P_TRAP = 11;
  localparam int K_LW = 0, K_SW = 1, K_R = 2, K_I = 3, K_JAL = 4, K_BEQ = 5, K_ILL = 6;

  logic       clk, reset, zero, mem_ready;
  logic [6:0] op;

  logic [1:0] aluop_h, srca_h, srcb_h, rsrc_h, imm_h;
  logic       adr_h, irw_h, pcw_h, regw_h, memw_h, ill_h, done_h;
  logic [3:0] st_h;
  logic [1:0] aluop_s, srca_s, srcb_s, rsrc_s, imm_s;
  logic       adr_s, irw_s, pcw_s, regw_s, memw_s, ill_s, done_s;
  logic [3:0] st_s;

  int tests = 0, fails = 0, cyc = 0;
  int n_done_h = 0, n_done_s = 0, n_irw_h = 0;
  string knames[7] = '{"lw", "sw", "rtype", "itype", "jal", "beq", "illegal"};

  multicycle_control_fsm #(.HALT_ON_ILLEGAL(1'b1), .STATE_W(4)) dut_h (
    .clk(clk), .reset(reset), .op(op), .zero(zero), .mem_ready(mem_ready),
    .ALUOp(aluop_h), .ALUSrcA(srca_h), .ALUSrcB(srcb_h), .ResultSrc(rsrc_h),
    .ImmSrc(imm_h), .AdrSrc(adr_h), .IRWrite(irw_h), .PCWrite(pcw_h),
    .RegWrite(regw_h), .MemWrite(memw_h), .illegal_instr(ill_h),
    .instr_done(done_h), .state_dbg(st_h)
  );

  multicycle_control_fsm #(.HALT_ON_ILLEGAL(1'b0), .STATE_W(4)) dut_s (
    .clk(clk), .reset(reset), .op(op), .zero(zero), .mem_ready(mem_ready),
    .ALUOp(aluop_s), .ALUSrcA(srca_s), .ALUSrcB(srcb_s), .ResultSrc(rsrc_s),
    .ImmSrc(imm_s), .AdrSrc(adr_s), .IRWrite(irw_s), .PCWrite(pcw_s),
    .RegWrite(regw_s), .MemWrite(memw_s), .illegal_instr(ill_s),
    .instr_done(done_s), .state_dbg(st_s)
  );

  logic [20:0] obs_h, obs_s;
  assign obs_h = {st_h, aluop_h, srca_h, srcb_h, rsrc_h, imm_h,
                  adr_h, irw_h, pcw_h, regw_h, memw_h, ill_h, done_h};
  assign obs_s = {st_s, aluop_s, srca_s, srcb_s, rsrc_s, imm_s,
                  adr_s, irw_s, pcw_s, regw_s, memw_s, ill_s, done_s};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected output vector for one cycle spent in a given phase of an instruction.
  function automatic logic [20:0] model(input int ph, input logic mr, input logic z,
                                        input logic rst, input logic [6:0] opv);
    logic [1:0] aluop, srca, srcb, rsrc, imm;
    logic       adr, irw, pcw, regw, memw, ill, done;
    {aluop, srca, srcb, rsrc, imm} = '0;
    {adr, irw, pcw, regw, memw, ill, done} = '0;
    case (ph)
      P_F:    begin srcb = 2'b10; rsrc = 2'b10; irw = mr; pcw = mr; end
      P_D:    begin srca = 2'b01; srcb = 2'b01; end
      P_MA:   begin srca = 2'b10; srcb = 2'b01; end
      P_MR:   adr = 1'b1;
      P_MWB:  begin rsrc = 2'b01; regw = 1'b1; done = 1'b1; end
      P_MW:   begin adr = 1'b1; memw = 1'b1; done = mr; end
      P_ER:   begin srca = 2'b10; aluop = 2'b10; end
      P_AWB:  begin regw = 1'b1; done = 1'b1; end
      P_EI:   begin srca = 2'b10; srcb = 2'b01; aluop = 2'b10; end
      P_JAL:  begin srca = 2'b01; srcb = 2'b10; pcw = 1'b1; end
      P_BEQ:  begin srca = 2'b10; aluop = 2'b01; pcw = z; done = 1'b1; end
      P_TRAP: ill = 1'b1;
      default: ;
    endcase
    case (opv)
      7'b0100011: imm = 2'b01;
      7'b1100011: imm = 2'b10;
      7'b1101111: imm = 2'b11;
      default:    imm = 2'b00;
    endcase
    if (rst) {irw, pcw, regw, memw, done} = '0;
    return {4'(ph), aluop, srca, srcb, rsrc, imm, adr, irw, pcw, regw, memw, ill, done};
  endfunction

  function automatic bit is_legal(input logic [6:0] o);
    return o inside {7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1101111, 7'b1100011};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one cycle's inputs on the falling edge and compare both instances just after.
  task automatic do_cycle(input int ph_h, input int ph_s, input logic mr, input logic z,
                          input logic rst, input logic [6:0] opv, input string tag);
    @(negedge clk);
    mem_ready = mr; zero = z; reset = rst; op = opv;
    #1;
    check($sformatf("%s/halt cyc%0d", tag, cyc), 32'(obs_h), 32'(model(ph_h, mr, z, rst, opv)));
    check($sformatf("%s/skip cyc%0d", tag, cyc), 32'(obs_s), 32'(model(ph_s, mr, z, rst, opv)));
    n_done_h += int'(done_h);
    n_done_s += int'(done_s);
    n_irw_h  += int'(irw_h);
    cyc++;
  endtask

  task automatic run_instr(input int kind, input bit rnd, input int st_f, input int st_m,
                           input logic zv, input int trap_n);
    int         q[$];
    int         ph, sf, sm, d0h, d0s, i0;
    logic       mr, z, rst;
    logic [6:0] opv;
    bit         aborted;
    sf = st_f; sm = st_m; aborted = 1'b0;
    d0h = n_done_h; d0s = n_done_s; i0 = n_irw_h;
    case (kind)
      K_LW:    begin opv = 7'b0000011; q = '{P_F, P_D, P_MA, P_MR, P_MWB}; end
      K_SW:    begin opv = 7'b0100011; q = '{P_F, P_D, P_MA, P_MW}; end
      K_R:     begin opv = 7'b0110011; q = '{P_F, P_D, P_ER, P_AWB}; end
      K_I:     begin opv = 7'b0010011; q = '{P_F, P_D, P_EI, P_AWB}; end
      K_JAL:   begin opv = 7'b1101111; q = '{P_F, P_D, P_JAL, P_AWB}; end
      K_BEQ:   begin opv = 7'b1100011; q = '{P_F, P_D, P_BEQ}; end
      default: begin
        opv = 7'h7F;
        if (rnd) while (is_legal(opv) || opv == 7'h7F) opv = 7'($urandom);
        q = '{P_F, P_D};
      end
    endcase
    while (q.size() > 0) begin
      ph = q[0];
      z  = rnd ? 1'($urandom_range(1)) : zv;
      if (rnd)                          mr = ($urandom_range(3) != 0);
      else if (ph == P_F)               mr = (sf == 0);
      else if (ph == P_MR || ph == P_MW) mr = (sm == 0);
      else                              mr = 1'($urandom_range(1));
      if (!rnd && !mr) begin
        if (ph == P_F) sf--;
        else if (ph == P_MR || ph == P_MW) sm--;
      end
      rst = rnd && (kind != K_ILL) && ($urandom_range(49) == 0);
      do_cycle(ph, ph, mr, z, rst, opv, knames[kind]);
      if (rst) begin
        aborted = 1'b1;
        q.delete();
      end else if (mr || !(ph == P_F || ph == P_MR || ph == P_MW)) begin
        void'(q.pop_front());
      end
    end
    if (kind == K_ILL) begin
      // Trapping copy sits in TRAP; skipping copy idles in FETCH with memory not ready.
      for (int k = 0; k < trap_n; k++)
        do_cycle(P_TRAP, P_F, 1'b0, 1'($urandom_range(1)), 1'b0, 7'($urandom), "trap");
      do_cycle(P_TRAP, P_F, 1'($urandom_range(1)), 1'($urandom_range(1)), 1'b1,
               7'($urandom), "trap_reset");
    end
    if (!aborted) begin
      check({knames[kind], " done_pulses/halt"}, 32'(n_done_h - d0h), (kind == K_ILL) ? 0 : 1);
      check({knames[kind], " done_pulses/skip"}, 32'(n_done_s - d0s), (kind == K_ILL) ? 0 : 1);
      check({knames[kind], " irwrite_pulses"},   32'(n_irw_h - i0), 1);
    end
  endtask

  initial begin
    reset = 1'b1; op = '0; zero = 1'b0; mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    do_cycle(P_F, P_F, 1'b0, 1'b0, 1'b1, 7'd0, "reset_state");

    run_instr(K_R,   1'b0, 0, 0, 1'b0, 0);
    run_instr(K_LW,  1'b0, 0, 2, 1'b0, 0);
    run_instr(K_BEQ, 1'b0, 0, 0, 1'b1, 0);
    run_instr(K_BEQ, 1'b0, 0, 0, 1'b0, 0);
    run_instr(K_SW,  1'b0, 1, 0, 1'b0, 0);
    run_instr(K_ILL, 1'b0, 0, 0, 1'b0, 20);

    // Reset lands while a store is still waiting on memory.
    do_cycle(P_F,  P_F,  1'b1, 1'b0, 1'b0, 7'b0100011, "sw_abort");
    do_cycle(P_D,  P_D,  1'b1, 1'b0, 1'b0, 7'b0100011, "sw_abort");
    do_cycle(P_MA, P_MA, 1'b1, 1'b0, 1'b0, 7'b0100011, "sw_abort");
    do_cycle(P_MW, P_MW, 1'b0, 1'b0, 1'b0, 7'b0100011, "sw_abort");
    do_cycle(P_MW, P_MW, 1'b0, 1'b0, 1'b1, 7'b0100011, "sw_abort_reset");

    run_instr(K_R,   1'b0, 0, 0, 1'b0, 0);
    run_instr(K_I,   1'b0, 0, 0, 1'b0, 0);
    run_instr(K_JAL, 1'b0, 2, 0, 1'b0, 0);
    run_instr(K_SW,  1'b0, 0, 3, 1'b0, 0);
    run_instr(K_LW,  1'b0, 1, 1, 1'b0, 0);

    for (int n = 0; n < 200; n++)
      run_instr(int'($urandom_range(6)), 1'b1, 0, 0, 1'b0, int'($urandom_range(4, 1)));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
- Main controller for the multi-cycle RISC-V core.
- Sequences the shared datapath (the single ALU, memory port, instruction register and PC) through fetch, decode, execute, memory and writeback steps.
- Drives the ALUOp code that our existing ALU decoder turns into ALUControl.
- Waits on a memory-ready handshake, and traps or skips on opcodes it does not support.

Parameters:
- HALT_ON_ILLEGAL, 1: 1 = enter TRAP on an unsupported opcode; 0 = discard the instruction and return to FETCH.
- STATE_W, 4: width of the state register and of state_dbg.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- op  in  7  opcode field of the instruction register.
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory handshake; the current access completes on the edge where this is 1.
- ALUOp  out  2  00 add, 01 subtract/compare, 10 decode funct3/funct7.
- ALUSrcA  out  2  00 PC, 01 OldPC, 10 rs1 data.
- ALUSrcB  out  2  00 rs2 data, 01 immediate, 10 constant 4.
- ResultSrc  out  2  00 ALUOut, 01 memory data, 10 ALU result.
- ImmSrc  out  2  00 I-type, 01 S-type, 10 B-type, 11 J-type.
- AdrSrc  out  1  0 PC, 1 ALUOut.
- IRWrite  out  1  instruction register load enable.
- PCWrite  out  1  PC load enable.
- RegWrite  out  1  register file write enable.
- MemWrite  out  1  data memory write enable.
- illegal_instr  out  1  high while in TRAP.
- instr_done  out  1  one-cycle pulse when an instruction retires.
- state_dbg  out  STATE_W  current state code.

Behaviour:
- State codes: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTER=6, ALUWB=7, EXECUTEI=8, JAL=9, BEQ=10, TRAP=11.
- Control outputs are Moore decodes of the state, except:
  - PCWrite = PCUpdate | (Branch & zero).
  - IRWrite and the PCUpdate term in FETCH are gated by mem_ready.
  - ImmSrc is a combinational function of op: lw and I-ALU 00, sw 01, beq 10, jal 11, anything else 00.
- Every enable or select not listed for a state is 0.
- Reset:
  - On a clock edge with reset=1, state becomes FETCH, from any state, including TRAP and mid-wait.
  - While reset=1, IRWrite, PCWrite, RegWrite, MemWrite and instr_done are forced to 0.
  - illegal_instr is 0 after reset; state_dbg is 0.
- FETCH:
  - Outputs: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10.
  - If mem_ready=1: IRWrite=1, PCUpdate=1, next state DECODE.
  - If mem_ready=0: stay in FETCH with no enables asserted, so the PC advances exactly once per fetch.
- DECODE:
  - Outputs: ALUSrcA=01, ALUSrcB=01, ALUOp=00 (branch target into ALUOut).
  - Next state by op: 0000011 or 0100011 -> MEMADR; 0110011 -> EXECUTER; 0010011 -> EXECUTEI; 1101111 -> JAL; 1100011 -> BEQ.
  - Any other op -> TRAP if HALT_ON_ILLEGAL=1, else FETCH.
- MEMADR:
  - Outputs: ALUSrcA=10, ALUSrcB=01, ALUOp=00.
  - op=0000011 -> MEMREAD, otherwise -> MEMWRITE.
- MEMREAD:
  - Outputs: AdrSrc=1, ResultSrc=00.
  - Stay until mem_ready=1, then -> MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1, instr_done=1, next state FETCH.
- MEMWRITE:
  - Outputs: AdrSrc=1, ResultSrc=00.
  - MemWrite=1 in every cycle of the state; memory commits on the mem_ready edge.
  - On mem_ready=1: instr_done=1, next state FETCH.
- EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUOp=10, next state ALUWB.
- EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=10, next state ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1, instr_done=1, next state FETCH.
- JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1 (PC<=target, ALU computes OldPC+4), next state ALUWB.
- BEQ:
  - Outputs: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1, instr_done=1, next state FETCH.
  - PCWrite equals zero in this cycle.
- TRAP:
  - All enables 0, illegal_instr=1.
  - Held until reset; mem_ready and op are ignored.
- Zero-wait latency (mem_ready tied 1), in cycles:
  - lw 5.
  - sw 4.
  - R-type and I-ALU 4.
  - jal 4.
  - beq 3.
- Each cycle of mem_ready=0 in FETCH, MEMREAD or MEMWRITE adds one cycle.
- Unknown state codes decode to FETCH on the next edge.

Test Plan:
- mem_ready=1, op=0110011 -> states 0,1,6,7,0; PCWrite only in cycle 0; RegWrite only in cycle 3; ALUOp=10 in cycle 2; instr_done at cycle 3.
- op=0000011, mem_ready low for 2 cycles in MEMREAD -> state 3 held 3 cycles; AdrSrc=1 throughout; MEMWB asserts RegWrite=1, ResultSrc=01; total 7 cycles.
- op=1100011: zero=1 -> PCWrite=1 in BEQ and ALUOp=01; repeat with zero=0 -> PCWrite=0; ImmSrc=10 in both runs.
- op=0100011, mem_ready=0 for 1 cycle in FETCH -> IRWrite and PCWrite asserted once, only on the ready cycle; MemWrite=1 in MEMWRITE; ImmSrc=01.
- op=1111111, HALT_ON_ILLEGAL=1 -> TRAP, illegal_instr=1 held for 20 cycles with no enables asserted; reset=1 for one edge -> FETCH, illegal_instr=0. HALT_ON_ILLEGAL=0 -> DECODE returns to FETCH, instr_done never asserted.
- reset=1 asserted while in MEMWRITE with mem_ready=0 -> MemWrite=0 during reset; state=0 after the edge; next fetch proceeds normally.
